// File: rtl/alu_share_arbiter_if.sv
// Bundle of request, ALU-side and response signals for alu_share_arbiter.
// slave = arbiter side, master = requesters/ALU/response consumer side.
interface alu_share_arbiter_if #(
  parameter int CNT_W = 16
);
  logic              req0_valid_i;
  logic              req0_ready_o;
  logic [31:0]       req0_src1_i;
  logic [31:0]       req0_src2_i;
  logic [3:0]        req0_ctrl_i;

  logic              req1_valid_i;
  logic              req1_ready_o;
  logic [31:0]       req1_src1_i;
  logic [31:0]       req1_src2_i;
  logic [3:0]        req1_ctrl_i;

  logic [31:0]       alu_src1_o;
  logic [31:0]       alu_src2_o;
  logic [3:0]        alu_ctrl_o;
  logic [31:0]       alu_result_i;
  logic              alu_zero_i;

  logic              rsp_valid_o;
  logic              rsp_ready_i;
  logic              rsp_id_o;
  logic [31:0]       rsp_result_o;
  logic              rsp_zero_o;

  logic              busy_o;
  logic [CNT_W-1:0]  op_count_o;

  modport slave (
    input  req0_valid_i, req0_src1_i, req0_src2_i, req0_ctrl_i,
    input  req1_valid_i, req1_src1_i, req1_src2_i, req1_ctrl_i,
    input  alu_result_i, alu_zero_i, rsp_ready_i,
    output req0_ready_o, req1_ready_o,
    output alu_src1_o, alu_src2_o, alu_ctrl_o,
    output rsp_valid_o, rsp_id_o, rsp_result_o, rsp_zero_o,
    output busy_o, op_count_o
  );

  modport master (
    output req0_valid_i, req0_src1_i, req0_src2_i, req0_ctrl_i,
    output req1_valid_i, req1_src1_i, req1_src2_i, req1_ctrl_i,
    output alu_result_i, alu_zero_i, rsp_ready_i,
    input  req0_ready_o, req1_ready_o,
    input  alu_src1_o, alu_src2_o, alu_ctrl_o,
    input  rsp_valid_o, rsp_id_o, rsp_result_o, rsp_zero_o,
    input  busy_o, op_count_o
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between two requesters: IDLE -> EXEC -> HOLD.
// Define ALU_ARB_RR_EN for round-robin arbitration; default is fixed priority (req0).
module alu_share_arbiter #(
  parameter int MULT_LAT = 3,
  parameter int CNT_W    = 16
) (
  input  logic               clk_i,
  input  logic               rst_n,
  alu_share_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [3:0] OP_MULT  = 4'b0011;
  localparam logic [3:0] MULT_CNT = 4'(MULT_LAT - 1);

  state_t           state, state_next;
  logic             grant;
  logic             accept, capture, complete;
  logic             last_grant;

  logic             op_id;
  logic [31:0]      op_src1, op_src2;
  logic [3:0]       op_ctrl;
  logic [3:0]       cnt;

  logic             rsp_valid, rsp_id, rsp_zero;
  logic [31:0]      rsp_result;
  logic [CNT_W-1:0] op_count;

  logic [31:0]      sel_src1, sel_src2;
  logic [3:0]       sel_ctrl;

  // With no request pending the grant parks on the previous winner; it is
  // never used then because accept and both readies need a valid request.
  always_comb begin
`ifdef ALU_ARB_RR_EN
    if (bus.req0_valid_i && bus.req1_valid_i) grant = ~last_grant;
    else if (bus.req0_valid_i)                grant = 1'b0;
    else if (bus.req1_valid_i)                grant = 1'b1;
    else                                      grant = last_grant;
`else
    if (bus.req0_valid_i)      grant = 1'b0;
    else if (bus.req1_valid_i) grant = 1'b1;
    else                       grant = last_grant;
`endif
  end

  assign sel_src1 = grant ? bus.req1_src1_i : bus.req0_src1_i;
  assign sel_src2 = grant ? bus.req1_src2_i : bus.req0_src2_i;
  assign sel_ctrl = grant ? bus.req1_ctrl_i : bus.req0_ctrl_i;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path
  // through the case leaves a variable unassigned (which would infer a latch).
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    capture    = 1'b0;
    complete   = 1'b0;
    case (state)
      IDLE: if (bus.req0_valid_i || bus.req1_valid_i) begin
        accept     = 1'b1;
        state_next = EXEC;
      end
      EXEC: if (cnt == 4'd0) begin
        capture    = 1'b1;
        state_next = HOLD;
      end
      HOLD: if (bus.rsp_ready_i) begin
        complete   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      op_id      <= 1'b0;
      op_src1    <= '0;
      op_src2    <= '0;
      op_ctrl    <= '0;
      cnt        <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      op_count   <= '0;
    end else begin
      if (accept) begin
        op_src1    <= sel_src1;
        op_src2    <= sel_src2;
        op_ctrl    <= sel_ctrl;
        op_id      <= grant;
        last_grant <= grant;
        cnt        <= (sel_ctrl == OP_MULT) ? MULT_CNT : 4'd0;
      end else if (state == EXEC && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end

      if (capture) begin
        rsp_result <= bus.alu_result_i;
        rsp_zero   <= bus.alu_zero_i;
        rsp_id     <= op_id;
        rsp_valid  <= 1'b1;
      end else if (complete) begin
        rsp_valid <= 1'b0;
        op_count  <= op_count + CNT_W'(1);
      end
    end
  end

  // Readies are gated by rst_n so every output reads 0 while reset is held,
  // even if a requester keeps its valid asserted.
  assign bus.req0_ready_o = rst_n && (state == IDLE) && !grant && bus.req0_valid_i;
  assign bus.req1_ready_o = rst_n && (state == IDLE) &&  grant && bus.req1_valid_i;

  assign bus.alu_src1_o   = op_src1;
  assign bus.alu_src2_o   = op_src2;
  assign bus.alu_ctrl_o   = op_ctrl;

  assign bus.rsp_valid_o  = rsp_valid;
  assign bus.rsp_id_o     = rsp_id;
  assign bus.rsp_result_o = rsp_result;
  assign bus.rsp_zero_o   = rsp_zero;

  assign bus.busy_o       = (state != IDLE);
  assign bus.op_count_o   = op_count;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a small behavioural ALU model.
// Expected request ids in the contention step depend on ALU_ARB_RR_EN.
module tb_alu_share_arbiter;

  localparam int MULT_LAT = 3;
  localparam int CNT_W    = 4;

  logic clk_i = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk_i = ~clk_i;

  alu_share_arbiter_if #(.CNT_W(CNT_W)) bus ();

  alu_share_arbiter #(.MULT_LAT(MULT_LAT), .CNT_W(CNT_W)) dut (
    .clk_i (clk_i),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  // Behavioural ALU: and, or, add, mul, sub; anything else is xor.
  logic [31:0] alu_y;
  always_comb begin
    case (bus.alu_ctrl_o)
      4'b0000: alu_y = bus.alu_src1_o & bus.alu_src2_o;
      4'b0001: alu_y = bus.alu_src1_o | bus.alu_src2_o;
      4'b0010: alu_y = bus.alu_src1_o + bus.alu_src2_o;
      4'b0011: alu_y = bus.alu_src1_o * bus.alu_src2_o;
      4'b0110: alu_y = bus.alu_src1_o - bus.alu_src2_o;
      default: alu_y = bus.alu_src1_o ^ bus.alu_src2_o;
    endcase
    bus.alu_result_i = alu_y;
    bus.alu_zero_i   = (alu_y == 32'd0);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_req(input bit id, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] c, input bit v);
    if (!id) begin
      bus.req0_src1_i  = a;
      bus.req0_src2_i  = b;
      bus.req0_ctrl_i  = c;
      bus.req0_valid_i = v;
    end else begin
      bus.req1_src1_i  = a;
      bus.req1_src2_i  = b;
      bus.req1_ctrl_i  = c;
      bus.req1_valid_i = v;
    end
  endtask

  // Called one tick after accept; returns k where rsp_valid first seen at T+k.
  task automatic wait_rsp(output int lat);
    lat = 1;
    while (bus.rsp_valid_o !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  // Full single-requester transaction with rsp_ready_i held at 1.
  task automatic do_op(input string tag, input bit id, input logic [31:0] a,
                       input logic [31:0] b, input logic [3:0] c, input logic [31:0] exp);
    int lat;
    drive_req(id, a, b, c, 1'b1);
    #1;
    check({tag, "_ready"}, 32'(id ? bus.req1_ready_o : bus.req0_ready_o), 1);
    tick();
    drive_req(id, 32'hDEAD_BEEF, 32'h1234_5678, 4'b1111, 1'b0);
    wait_rsp(lat);
    check({tag, "_lat"}, lat, (c == 4'b0011) ? MULT_LAT + 1 : 2);
    check({tag, "_result"}, bus.rsp_result_o, exp);
    check({tag, "_zero"}, 32'(bus.rsp_zero_o), (exp == 32'd0) ? 1 : 0);
    check({tag, "_id"}, 32'(bus.rsp_id_o), 32'(id));
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bit exp_id;

    drive_req(1'b0, '0, '0, '0, 1'b0);
    drive_req(1'b1, '0, '0, '0, 1'b0);
    bus.rsp_ready_i = 1'b1;

    // Power-on reset values
    tick();
    tick();
    check("rst_busy",      32'(bus.busy_o),      0);
    check("rst_rsp_valid", 32'(bus.rsp_valid_o), 0);
    check("rst_result",    bus.rsp_result_o,     0);
    check("rst_count",     32'(bus.op_count_o),  0);
    check("rst_alu_src1",  bus.alu_src1_o,       0);
    check("rst_alu_ctrl",  32'(bus.alu_ctrl_o),  0);
    rst_n = 1'b1;
    tick();

    // req0 add 5+7
    do_op("add", 1'b0, 32'd5, 32'd7, 4'b0010, 32'd12);
    check("add_count",     32'(bus.op_count_o),  1);
    check("add_busy",      32'(bus.busy_o),      0);
    check("add_rsp_clear", 32'(bus.rsp_valid_o), 0);

    // req1 mult -3*4; req0 arrives during EXEC and must wait for IDLE
    drive_req(1'b1, 32'hFFFF_FFFD, 32'd4, 4'b0011, 1'b1);
    #1;
    check("mul_ready1", 32'(bus.req1_ready_o), 1);
    check("mul_ready0", 32'(bus.req0_ready_o), 0);
    tick();
    drive_req(1'b1, '0, '0, '0, 1'b0);
    drive_req(1'b0, 32'd1, 32'd1, 4'b0010, 1'b1);
    #1;
    for (int k = 1; k <= 3; k++) begin
      check("mul_wait_ready0", 32'(bus.req0_ready_o), 0);
      check("mul_wait_valid",  32'(bus.rsp_valid_o),  0);
      tick();
    end
    check("mul_valid",      32'(bus.rsp_valid_o),  1);
    check("mul_result",     bus.rsp_result_o,      32'hFFFF_FFF4);
    check("mul_id",         32'(bus.rsp_id_o),     1);
    check("mul_zero",       32'(bus.rsp_zero_o),   0);
    check("mul_hold_ready", 32'(bus.req0_ready_o), 0);
    tick();
    check("mul_idle_ready0", 32'(bus.req0_ready_o), 1);
    check("mul_count",       32'(bus.op_count_o),   2);
    tick();
    drive_req(1'b0, '0, '0, '0, 1'b0);
    wait_rsp(lat);
    check("after_mul_lat",    lat, 2);
    check("after_mul_result", bus.rsp_result_o, 2);
    check("after_mul_id",     32'(bus.rsp_id_o), 0);
    tick();
    check("after_mul_count",  32'(bus.op_count_o), 3);

    // Asynchronous reset in the middle of a multiply
    drive_req(1'b1, 32'd6, 32'd7, 4'b0011, 1'b1);
    #1;
    tick();
    tick();
    check("mid_busy",     32'(bus.busy_o), 1);
    check("mid_alu_src1", bus.alu_src1_o,  6);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy",     32'(bus.busy_o),       0);
    check("arst_valid",    32'(bus.rsp_valid_o),  0);
    check("arst_result",   bus.rsp_result_o,      0);
    check("arst_alu_src1", bus.alu_src1_o,        0);
    check("arst_alu_src2", bus.alu_src2_o,        0);
    check("arst_alu_ctrl", 32'(bus.alu_ctrl_o),   0);
    check("arst_count",    32'(bus.op_count_o),   0);
    check("arst_ready1",   32'(bus.req1_ready_o), 0);
    tick();
    drive_req(1'b1, '0, '0, '0, 1'b0);
    rst_n = 1'b1;
    tick();
    tick();
    check("post_arst_valid", 32'(bus.rsp_valid_o), 0);
    check("post_arst_busy",  32'(bus.busy_o),      0);

    // Both requesters valid continuously for four operations
    drive_req(1'b0, 32'd10, 32'd1, 4'b0010, 1'b1);
    drive_req(1'b1, 32'd20, 32'd2, 4'b0010, 1'b1);
    #1;
    for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARB_RR_EN
      exp_id = (i % 2 == 1);
`else
      exp_id = 1'b0;
`endif
      check("both_ready0", 32'(bus.req0_ready_o), exp_id ? 0 : 1);
      check("both_ready1", 32'(bus.req1_ready_o), exp_id ? 1 : 0);
      tick();
      wait_rsp(lat);
      check("both_lat",    lat, 2);
      check("both_id",     32'(bus.rsp_id_o), 32'(exp_id));
      check("both_result", bus.rsp_result_o, exp_id ? 22 : 11);
      tick();
    end
    drive_req(1'b0, '0, '0, '0, 1'b0);
    drive_req(1'b1, '0, '0, '0, 1'b0);
    check("both_count", 32'(bus.op_count_o), 4);

    // sub 9-9 with response back-pressure
    bus.rsp_ready_i = 1'b0;
    drive_req(1'b0, 32'd9, 32'd9, 4'b0110, 1'b1);
    #1;
    tick();
    drive_req(1'b0, '0, '0, '0, 1'b0);
    wait_rsp(lat);
    check("sub_lat",    lat, 2);
    check("sub_result", bus.rsp_result_o, 0);
    check("sub_zero",   32'(bus.rsp_zero_o), 1);
    check("sub_id",     32'(bus.rsp_id_o), 0);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("hold_valid",  32'(bus.rsp_valid_o), 1);
      check("hold_zero",   32'(bus.rsp_zero_o),  1);
      check("hold_result", bus.rsp_result_o,     0);
      check("hold_busy",   32'(bus.busy_o),      1);
      check("hold_count",  32'(bus.op_count_o),  4);
    end
    bus.rsp_ready_i = 1'b1;
    tick();
    check("sub_done_valid", 32'(bus.rsp_valid_o), 0);
    check("sub_done_count", 32'(bus.op_count_o),  5);

    // Drive op_count to 2^CNT_W-1, then one more completion wraps it to 0
    for (int i = 0; i < 10; i++) begin
      do_op("fill", 1'b0, 32'(i), 32'd100, 4'b0010, 32'(i + 100));
    end
    check("count_max", 32'(bus.op_count_o), 15);
    do_op("wrap_mul", 1'b1, 32'd7, 32'd6, 4'b0011, 32'd42);
    check("count_wrap", 32'(bus.op_count_o), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
